// File: rtl/parking_fee_calc_pkg.sv
// Shared constants and FSM state type for the parking fee path.
// Timer width is common to the timer, capture and fee stages.
package parking_pkg;

    localparam int TIME_W = 11;

    localparam int FREE_TICKS_DEF = 15;
    localparam int UNIT_TICKS_DEF = 60;
    localparam int RATE_DEF       = 10;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        COUNT,
        DONE
    } fee_state_t;

endpackage

// File: rtl/parking_fee_calc_if.sv
// Exit-request / fee-result bundle between the exit controller
// and the fee calculator.
interface parking_fee_calc_if
    import parking_pkg::*;
#(
    parameter int TW = TIME_W,
    parameter int FW = 12
);

    logic          start;
    logic [TW-1:0] timer;
    logic [TW-1:0] entry_time;
    logic          busy;
    logic          done;
    logic [TW-1:0] duration;
    logic [FW-1:0] fee;

    modport master (
        output start, timer, entry_time,
        input  busy, done, duration, fee
    );

    modport slave (
        input  start, timer, entry_time,
        output busy, done, duration, fee
    );

endinterface

// File: rtl/parking_fee_calc.sv
// Exit fee calculator: elapsed time from entry stamp, then an
// iterative per-block fee accumulation with saturation.
module parking_fee_calc
    import parking_pkg::*;
#(
    parameter int FREE_TICKS = FREE_TICKS_DEF,
    parameter int UNIT_TICKS = UNIT_TICKS_DEF,
    parameter int RATE       = RATE_DEF,
    parameter int FEE_W      = 12,
    parameter int MAX_FEE    = 4095
) (
    input logic clk,
    input logic rst,
    parking_fee_calc_if.slave bus
);

    localparam logic [TIME_W-1:0] FREE_T = TIME_W'(FREE_TICKS);
    localparam logic [TIME_W-1:0] UNIT_T = TIME_W'(UNIT_TICKS);
    localparam logic [FEE_W:0]    RATE_X = (FEE_W+1)'(RATE);
    localparam logic [FEE_W:0]    MAX_X  = (FEE_W+1)'(MAX_FEE);

    fee_state_t        state;
    logic              busy_q;
    logic              done_q;
    logic [TIME_W-1:0] dur_q;
    logic [TIME_W-1:0] rem_q;
    logic [FEE_W-1:0]  fee_q;
    logic [FEE_W:0]    fee_sum;
    logic [FEE_W-1:0]  fee_next;

    // Next fee value: one extra bit so the add cannot wrap before the cap.
    always_comb begin
        fee_sum  = {1'b0, fee_q} + RATE_X;
        fee_next = (fee_sum > MAX_X) ? FEE_W'(MAX_FEE)
                                     : fee_sum[FEE_W-1:0];
    end

    // Control FSM with registered busy/done and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dur_q  <= '0;
            rem_q  <= '0;
            fee_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        dur_q  <= bus.timer - bus.entry_time;
                        fee_q  <= '0;
                        busy_q <= 1'b1;
                        state  <= PREP;
                    end
                end
                PREP: begin
                    if (dur_q <= FREE_T) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        rem_q <= dur_q - FREE_T;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    fee_q <= fee_next;
                    if (rem_q <= UNIT_T) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        rem_q <= rem_q - UNIT_T;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.duration = dur_q;
    assign bus.fee      = fee_q;

endmodule

// File: tb/tb_parking_fee_calc.sv
// Directed bench for parking_fee_calc: transaction-level model plus
// literal expectations; a second instance runs with a low fee cap.
module tb_parking_fee_calc;
    import parking_pkg::*;

    localparam int FREE = 15;
    localparam int UNIT = 60;
    localparam int RT   = 10;
    localparam int CAPA = 4095;
    localparam int CAPB = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [TIME_W-1:0] timer = '0;
    logic [TIME_W-1:0] entry = '0;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    parking_fee_calc_if #(.TW(TIME_W), .FW(12)) ba ();
    parking_fee_calc_if #(.TW(TIME_W), .FW(12)) bb ();

    assign ba.start = start;
    assign ba.timer = timer;
    assign ba.entry_time = entry;
    assign bb.start = start;
    assign bb.timer = timer;
    assign bb.entry_time = entry;

    parking_fee_calc #(.MAX_FEE(CAPA)) dut_a (
        .clk(clk), .rst(rst), .bus(ba.slave)
    );

    parking_fee_calc #(.MAX_FEE(CAPB)) dut_b (
        .clk(clk), .rst(rst), .bus(bb.slave)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Behavioural model: whole-transaction arithmetic.
    int m_busy, m_done, m_dur, m_fa, m_fb, m_left, f_a, f_b;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_dur = 0;
            m_fa = 0; m_fb = 0; m_left = 0;
        end else if (m_done != 0) begin
            m_done = 0;
            m_busy = 0;
        end else if (m_busy != 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                m_fa = f_a;
                m_fb = f_b;
            end
        end else if (start) begin
            int k;
            m_dur = (int'(timer) - int'(entry) + 2048) % 2048;
            k = (m_dur <= FREE) ? 0 : (m_dur - FREE + UNIT - 1) / UNIT;
            f_a = (k * RT > CAPA) ? CAPA : k * RT;
            f_b = (k * RT > CAPB) ? CAPB : k * RT;
            m_fa = 0;
            m_fb = 0;
            m_left = 1 + k;
            m_busy = 1;
        end
        armed = 1'b1;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("busy", int'(ba.busy), m_busy);
            chk("done", int'(ba.done), m_done);
            chk("duration", int'(ba.duration), m_dur);
            chk("busy_b", int'(bb.busy), m_busy);
            chk("done_b", int'(bb.done), m_done);
            if (m_busy == 0 || m_done != 0) begin
                chk("fee", int'(ba.fee), m_fa);
                chk("fee_b", int'(bb.fee), m_fb);
            end
        end
    end

    task automatic run(input int e, input int t, input int xd,
                       input int xf, input int xfb, input int xk,
                       input bit poke);
        int n;
        @(negedge clk);
        entry = TIME_W'(e);
        timer = TIME_W'(t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        timer = TIME_W'(t + 333);
        entry = TIME_W'(e + 7);
        n = 0;
        while (!ba.done && n < 100) begin
            @(negedge clk);
            n++;
            if (poke && n == 5) begin
                timer = 11'd5;
                entry = 11'd0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("latency", n, 1 + xk);
        chk("lit_dur", int'(ba.duration), xd);
        chk("lit_fee", int'(ba.fee), xf);
        chk("lit_fee_cap", int'(bb.fee), xfb);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(ba.busy), 0);
        chk("rst_done", int'(ba.done), 0);
        chk("rst_dur", int'(ba.duration), 0);
        chk("rst_fee", int'(ba.fee), 0);
        rst = 1'b0;
        @(negedge clk);

        run(100, 115, 15, 0, 0, 0, 1'b0);
        run(100, 116, 16, 10, 10, 1, 1'b0);
        run(100, 175, 75, 10, 10, 1, 1'b0);
        run(100, 176, 76, 20, 20, 2, 1'b0);
        run(2000, 50, 98, 20, 20, 2, 1'b0);
        run(0, 2047, 2047, 340, 100, 34, 1'b0);
        run(0, 2047, 2047, 340, 100, 34, 1'b1);

        repeat (20) @(negedge clk);
        chk("hold_dur", int'(ba.duration), 2047);
        chk("hold_fee", int'(ba.fee), 340);

        @(negedge clk);
        entry = 11'd0;
        timer = 11'd2047;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(ba.busy), 0);
        chk("abort_dur", int'(ba.duration), 0);
        chk("abort_fee", int'(ba.fee), 0);
        repeat (40) @(negedge clk);
        chk("abort_nodone", int'(ba.done), 0);

        run(100, 176, 76, 20, 20, 2, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parking_fee_calc.md
Name: parking_fee_calc

Overview:
- Downstream consumer of the captured entry timestamp (11-bit snapshot of the free-running parking timer).
- On a car-exit request, computes elapsed parking time as current timer minus stored entry time, modulo 2^11.
- Converts the elapsed time to a fee: a free grace period, then RATE per started UNIT_TICKS block, saturated at MAX_FEE.
- Multi-cycle iterative FSM with no multiplier or divider; results go to the display/payment logic.

Parameters:
- TIME_W, 11, width of timer and entry-time values.
- FREE_TICKS, 15, grace period in ticks; a duration at or below this value costs 0.
- UNIT_TICKS, 60, billing block length in ticks; must be >= 1.
- RATE, 10, fee added per started block.
- FEE_W, 12, fee output width.
- MAX_FEE, 4095, saturation cap; must be <= 2^FEE_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- timer  in  TIME_W  current free-running tick count.
- entry_time  in  TIME_W  stored entry timestamp from the capture stage.
- start  in  1  exit request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when duration and fee are valid.
- duration  out  TIME_W  elapsed ticks.
- fee  out  FEE_W  computed charge.

Behaviour:
- Only one clock; reset is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, duration=0, fee=0, internal remainder=0.
- rst asserted in any state aborts the computation at the next edge, with no done pulse.
- States: IDLE, PREP, COUNT, DONE.
- IDLE: if start=1 at an edge:
  - duration <= (timer - entry_time) mod 2^TIME_W; wrap-around is natural, with no underflow flag.
  - fee <= 0; next state PREP.
- PREP:
  - If duration <= FREE_TICKS: next state DONE; fee stays 0.
  - Else: rem <= duration - FREE_TICKS; next state COUNT.
- COUNT, one block per cycle:
  - fee <= min(fee + RATE, MAX_FEE); compute the sum at FEE_W+1 bits before the compare.
  - If rem <= UNIT_TICKS: next state DONE.
  - Else: rem <= rem - UNIT_TICKS.
- DONE: done=1 for exactly this cycle; next state IDLE.
- Latency: with k = ceil((duration-FREE_TICKS)/UNIT_TICKS), or 0 if free:
  - done is high in the cycle after edge 1+k, counting from the start-sampling edge as edge 0.
  - Worst case with defaults: k = 34.
- Output hold: duration and fee hold their last values after DONE until the next accepted start.
- Saturation: once fee reaches MAX_FEE, COUNT continues to exhaust rem, but fee stays at MAX_FEE.
- start while busy=1 is ignored and not queued.
- start held high continuously restarts a new calculation in the cycle after DONE. This is legal; the bench must pulse start.
- timer and entry_time are sampled only at the IDLE accept edge; changes afterwards have no effect.

Decomposition:
- Shared package parking_pkg holds:
  - TIME_W = 11, shared with the timer and the capture stage.
  - The fee-state enum {IDLE, PREP, COUNT, DONE}.
  - The default FREE_TICKS, UNIT_TICKS and RATE constants.
- No sub-module: the modulo subtraction and the iterative block counter stay inline.

Test Plan:
- Free exit: entry_time=100, timer=115, start pulse → duration=15, fee=0; done at edge 1 after the sampling edge; busy=1 for 2 cycles.
- One block: entry_time=100, timer=116 → duration=16, fee=10, k=1. Also timer=175 → duration=75, rem=60, fee=10. Also timer=176 → duration=76, fee=20.
- Timer wrap: entry_time=2000, timer=50 → duration=98, fee=20.
- Maximum duration: entry_time=0, timer=2047 → duration=2047, fee=340, done 35 edges after sampling. Re-run with MAX_FEE=100 → fee=100.
- Busy protection and hold: pulse start mid-COUNT with different inputs → ignored, original result delivered; outputs unchanged for 20 idle cycles afterwards.
- Reset mid-operation: assert rst during COUNT → next cycle state=IDLE, busy=0, fee=0, duration=0, no done pulse. A fresh start then behaves normally.
